// File: rtl/imm_sequencer.sv
// imm_sequencer: sequences ZEXT/SEXT/HIGH/WIDE immediates through an external zero-extender into a register write.
module imm_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  imm_in,
  input  logic        lo_valid,
  input  logic        abort,
  output logic [7:0]  ext_in,
  input  logic [15:0] ext_out,
  output logic [15:0] imm_out,
  output logic        reg_wr_en,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT_LO, EXT, WRITE} state_t;
  localparam logic [3:0] TMO = 4'(TIMEOUT);
  state_t state, nxt;
  logic [1:0] mode_r;
  logic [7:0] byte_a, byte_b;
  logic [3:0] cnt;
  logic [15:0] imm_load;
  logic waiting;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (mode == 2'b11) ? WAIT_LO : EXT;
      WAIT_LO: nxt = abort ? IDLE : lo_valid ? EXT : (cnt == TMO) ? IDLE : WAIT_LO;
      EXT:     nxt = WRITE;
      WRITE:   nxt = IDLE;
    endcase
  end
  // idle WAIT_LO cycle: neither abort nor lo_valid arrived
  assign waiting   = (state == WAIT_LO) && !abort && !lo_valid;
  assign err       = waiting && (cnt == TMO);
  assign busy      = (state != IDLE);
  assign reg_wr_en = (state == WRITE);
  assign ext_in    = (state != EXT) ? 8'h00 : (mode_r == 2'b11) ? byte_b : byte_a;
  assign imm_load  = (mode_r == 2'b00) ? ext_out :
                     (mode_r == 2'b01) ? {{8{ext_in[7]}}, ext_out[7:0]} :
                     (mode_r == 2'b10) ? {byte_a, 8'h00} : {byte_a, ext_out[7:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mode_r  <= 2'b00;
      byte_a  <= 8'h00;
      byte_b  <= 8'h00;
      cnt     <= 4'd0;
      imm_out <= 16'h0000;
    end else begin
      state <= nxt;
      cnt   <= (waiting && cnt != TMO) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && start) begin
        mode_r <= mode;
        byte_a <= imm_in;
      end
      if (state == WAIT_LO && !abort && lo_valid) byte_b <= imm_in;
      if (state == EXT) imm_out <= imm_load;
    end
  end
endmodule

// File: doc/imm_sequencer.md
IMM_SEQUENCER -- requirements
Module: imm_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles spent in WAIT_LO before giving up (range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 The block SHALL have port mode  input  2  immediate mode: 00 ZEXT, 01 SEXT, 10 HIGH, 11 WIDE.
REQ-006 The block SHALL have port imm_in  input  8  immediate byte (high byte for WIDE at start, low byte at lo_valid).
REQ-007 The block SHALL have port lo_valid  input  1  second-byte strobe for WIDE, sampled only in WAIT_LO.
REQ-008 The block SHALL have port abort  input  1  cancels a pending WIDE in WAIT_LO.
REQ-009 The block SHALL have port ext_in  output  8  byte driven to the zero-extender.
REQ-010 The block SHALL have port ext_out  input  16  zero-extender result ({8'h00, ext_in}).
REQ-011 The block SHALL have port imm_out  output  16  registered assembled immediate.
REQ-012 The block SHALL have port reg_wr_en  output  1  one-cycle register-file write strobe.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port err  output  1  one-cycle pulse on WAIT_LO timeout.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_LO, EXT, WRITE, and no others.
REQ-016 In IDLE with start=1, the block SHALL capture mode and imm_in (as byte_a) and go to EXT for modes 00/01/10, or WAIT_LO for mode 11.
REQ-017 In IDLE with start=0, the block SHALL remain in IDLE; start while busy=1 SHALL be ignored (no queueing).
REQ-018 In WAIT_LO, lo_valid=1 SHALL capture imm_in as byte_b and go to EXT; the wait counter clears.
REQ-019 In WAIT_LO, abort=1 SHALL return to IDLE with no write and no err; abort has priority over lo_valid in the same cycle.
REQ-020 In WAIT_LO, a 4-bit counter SHALL increment each cycle without lo_valid/abort; at count reaching TIMEOUT, next state IDLE, err=1 for exactly one cycle, no write.
REQ-021 ext_in SHALL be byte_a in EXT for modes 00/01/10, byte_b in EXT for mode 11, and 8'h00 in every other state.
REQ-022 At the end of EXT, imm_out SHALL be loaded with: ZEXT ext_out; SEXT {{8{ext_in[7]}}, ext_out[7:0]}; HIGH {byte_a, 8'h00}; WIDE {byte_a, ext_out[7:0]}.
REQ-023 EXT SHALL always last exactly one cycle and proceed to WRITE.
REQ-024 In WRITE, reg_wr_en SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-025 imm_out SHALL hold its value from WRITE until the next EXT load.
REQ-026 Latency SHALL be: modes 00/01/10, start cycle N -> reg_wr_en in cycle N+2; mode 11, lo_valid cycle M -> reg_wr_en in cycle M+2.
REQ-027 busy SHALL be asserted from the cycle after start acceptance through WRITE inclusive.
REQ-028 Back-to-back: start may be accepted in the IDLE cycle immediately following WRITE.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, imm_out=16'h0000, reg_wr_en=0, busy=0, err=0, ext_in=8'h00, counter=0, byte_a=byte_b=8'h00.
REQ-030 Reset during WAIT_LO, EXT or WRITE SHALL abandon the operation with no write after reset deassertion.
REQ-031 First start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 ZEXT: start, mode=00, imm_in=8'hA5 at cycle 0 -> cycle 2 reg_wr_en=1, imm_out=16'h00A5, busy=1 in cycles 1-2.
REQ-033 SEXT: mode=01, imm_in=8'hF0 -> imm_out=16'hFFF0; mode=01, imm_in=8'h70 -> imm_out=16'h0070.
REQ-034 HIGH then WIDE: mode=10, imm_in=8'h12 -> 16'h1200; mode=11, imm_in=8'h12, 3 idle cycles, lo_valid with imm_in=8'h34 -> 2 cycles later imm_out=16'h1234, reg_wr_en=1.
REQ-035 Timeout/abort: mode=11 with no lo_valid -> err pulse after TIMEOUT=15 cycles, no reg_wr_en; repeat with abort and lo_valid together in cycle 2 -> IDLE, no write, no err.
REQ-036 Reset mid-op: reset asserted in EXT of a ZEXT 8'hFF request -> outputs zero immediately, no reg_wr_en afterwards; start ignored while busy=1 (second start 8'h11 during first request does not alter result 8'hA5).
